// File: rtl/spike_step_scheduler.sv
// rtl/spike_step_scheduler.sv - per-timestep spike drain and synapse-row request sequencer
// Optional tick-overrun monitor ports are enabled by defining SCHED_OVERRUN_EN.
module spike_step_scheduler #(
  parameter int NR_DEPTH   = 16,
  parameter int SR_DEPTH   = 16384,
  parameter int FIFO_DEPTH = 16,
  parameter int TIME_WIDTH = 16,
  localparam int SIW  = (NR_DEPTH > 1) ? $clog2(NR_DEPTH) : 1,
  localparam int SAW  = (SR_DEPTH > 1) ? $clog2(SR_DEPTH) : 1,
  localparam int ROWS = SR_DEPTH / NR_DEPTH,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int AW   = $clog2(FIFO_DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spk_valid,
  output logic                  spk_ready,
  input  logic [SIW-1:0]        spk_idx,
  input  logic                  tick,
  input  logic                  freeze,
  output logic                  sr_req_valid,
  input  logic                  sr_req_ready,
  output logic [SAW-1:0]        sr_addr,
  output logic                  sr_last,
  output logic                  busy,
  output logic                  step_done,
`ifdef SCHED_OVERRUN_EN
  output logic [TIME_WIDTH-1:0] time_index,
  output logic                  overrun,
  output logic [7:0]            overrun_cnt
`else
  output logic [TIME_WIDTH-1:0] time_index
`endif
);

  typedef enum logic [1:0] {IDLE, POP, ISSUE, DONE} state_t;

  state_t                  state;
  logic [SIW-1:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [CW-1:0]           count;
  logic [CW-1:0]           remaining;
  logic [RW-1:0]           row;
  logic [SAW-1:0]          addr_q;
  logic [SAW-1:0]          head_base;
  logic [TIME_WIDTH-1:0]   time_q;
  logic                    push;
  logic                    pop;
  logic                    hs;
  logic                    last_row;

  // Readiness comes only from the registered count, so a full FIFO never
  // accepts a spike in the same cycle one is popped.
  assign spk_ready    = (count < CW'(FIFO_DEPTH));
  assign push         = spk_valid & spk_ready;
  assign pop          = (state == POP) && !freeze && (remaining != '0);
  assign last_row     = (row == RW'(ROWS - 1));
  assign head_base    = SAW'(mem[rd_ptr]) * SAW'(ROWS);

  assign sr_req_valid = (state == ISSUE) && !freeze;
  assign hs           = sr_req_valid && sr_req_ready;
  assign sr_addr      = addr_q;
  assign sr_last      = (state == ISSUE) && last_row;
  assign busy         = (state != IDLE);
  assign step_done    = (state == DONE) && !freeze;
  assign time_index   = time_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= spk_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The step size is snapshotted at the tick, so spikes arriving during the
  // step (or in the tick cycle itself) wait for the following step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
      row       <= '0;
      addr_q    <= '0;
      time_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            remaining <= count;
            state     <= POP;
          end
        end
        POP: begin
          if (!freeze) begin
            if (remaining == '0) begin
              state <= DONE;
            end else begin
              addr_q <= head_base;
              row    <= '0;
              state  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (hs) begin
            if (last_row) begin
              remaining <= remaining - CW'(1);
              state     <= POP;
            end else begin
              row    <= row + RW'(1);
              addr_q <= addr_q + SAW'(1);
            end
          end
        end
        DONE: begin
          if (!freeze) begin
            time_q <= time_q + TIME_WIDTH'(1);
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCHED_OVERRUN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else if (tick && busy) begin
      overrun <= 1'b1;
      if (overrun_cnt != 8'hFF) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spike_step_scheduler.sv
// tb/tb_spike_step_scheduler.sv - directed scoreboard bench for spike_step_scheduler
module tb_spike_step_scheduler;
  localparam int NR = 4;
  localparam int SR = 16;
  localparam int FD = 4;
  localparam int TW = 16;
  localparam int ROWS = SR / NR;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          spk_valid = 1'b0;
  logic          spk_ready;
  logic [1:0]    spk_idx = '0;
  logic          tick = 1'b0;
  logic          freeze = 1'b0;
  logic          sr_req_valid;
  logic          sr_req_ready = 1'b1;
  logic [3:0]    sr_addr;
  logic          sr_last;
  logic          busy;
  logic          step_done;
  logic [TW-1:0] time_index;
`ifdef SCHED_OVERRUN_EN
  logic          overrun;
  logic [7:0]    overrun_cnt;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int exp_steps = 0;
  int exp_time = 0;
  int exp_q[$];

  spike_step_scheduler #(
    .NR_DEPTH(NR), .SR_DEPTH(SR), .FIFO_DEPTH(FD), .TIME_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset),
    .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_idx(spk_idx),
    .tick(tick), .freeze(freeze),
    .sr_req_valid(sr_req_valid), .sr_req_ready(sr_req_ready),
    .sr_addr(sr_addr), .sr_last(sr_last),
    .busy(busy), .step_done(step_done),
`ifdef SCHED_OVERRUN_EN
    .time_index(time_index), .overrun(overrun), .overrun_cnt(overrun_cnt)
`else
    .time_index(time_index)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every accepted request must match the next expected {addr,last}.
  always @(negedge clk) begin
    int e;
    if (reset && sr_req_valid && sr_req_ready) begin
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_req: observed addr=%0d expected no request", sr_addr);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        assert ({28'd0, sr_addr, sr_last} === 32'(e)) else begin
          n_fail++;
          $error("FAIL req: observed addr=%0d last=%0d expected addr=%0d last=%0d",
                 sr_addr, sr_last, e / 2, e % 2);
        end
      end
    end
    if (reset && step_done) done_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_spike(input int s);
    for (int r = 0; r < ROWS; r++) exp_q.push_back(((s * ROWS + r) * 2) + ((r == ROWS - 1) ? 1 : 0));
  endtask

  task automatic push(input int s, input string tag);
    chk({tag, "_ready"}, 32'(spk_ready), 32'd1);
    spk_valid = 1'b1;
    spk_idx = 2'(s);
    cyc();
    spk_valid = 1'b0;
    expect_spike(s);
  endtask

  task automatic wait_done(input int c0, input int exp_c, input string tag);
    int c;
    c = c0;
    while (!step_done && c < 300) begin
      cyc();
      tick = 1'b0;
      spk_valid = 1'b0;
      c++;
    end
    chk({tag, "_done_seen"}, 32'(step_done), 32'd1);
    chk({tag, "_done_cycle"}, 32'(c), 32'(exp_c));
    cyc();
    exp_time++;
    exp_steps++;
    chk({tag, "_time"}, 32'(time_index), 32'(exp_time));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'(exp_steps));
    chk({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_step(input int exp_c, input string tag);
    tick = 1'b1;
    wait_done(0, exp_c, tag);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_spk_ready"}, 32'(spk_ready), 32'd1);
    chk({tag, "_valid"}, 32'(sr_req_valid), 32'd0);
    chk({tag, "_addr"}, 32'(sr_addr), 32'd0);
    chk({tag, "_last"}, 32'(sr_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_step_done"}, 32'(step_done), 32'd0);
    chk({tag, "_time"}, 32'(time_index), 32'd0);
`ifdef SCHED_OVERRUN_EN
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    chk({tag, "_overrun_cnt"}, 32'(overrun_cnt), 32'd0);
`endif
  endtask

  initial begin
    reset = 1'b0;
    #1;
    chk_reset_outputs("por");
    cyc();
    cyc();
    reset = 1'b1;
    cyc();

    // Empty step: done at cycle 2, no requests.
    run_step(2, "empty");

    // Two spikes: 8..11 then 0..3.
    push(2, "p2");
    push(0, "p0");
    run_step(2 + 2 * (1 + ROWS), "two");

    // Fill FIFO, hold a fifth push until the first pop frees a slot.
    push(1, "f1");
    push(2, "f2");
    push(3, "f3");
    push(0, "f4");
    chk("full_ready", 32'(spk_ready), 32'd0);
    spk_valid = 1'b1;
    spk_idx = 2'd2;
    tick = 1'b1;
    chk("full_c0_ready", 32'(spk_ready), 32'd0);
    cyc();
    tick = 1'b0;
    chk("full_c1_ready", 32'(spk_ready), 32'd0);
    chk("full_c1_busy", 32'(busy), 32'd1);
    cyc();
    chk("full_c2_ready", 32'(spk_ready), 32'd1);
    cyc();
    spk_valid = 1'b0;
    chk("full_c3_ready", 32'(spk_ready), 32'd0);
    wait_done(3, 2 + 4 * (1 + ROWS), "full");
    expect_spike(2);
    run_step(2 + (1 + ROWS), "fifth");

    // Spike pushed in the tick cycle belongs to the next step.
    spk_valid = 1'b1;
    spk_idx = 2'd1;
    run_step(2, "tick_push");
    expect_spike(1);
    run_step(2 + (1 + ROWS), "tick_push_next");

    // Freeze for three cycles while address 5 is pending.
    push(1, "fz");
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    cyc();
    freeze = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("freeze_valid", 32'(sr_req_valid), 32'd0);
      chk("freeze_addr", 32'(sr_addr), 32'd5);
      if (k < 2) cyc();
    end
    cyc();
    freeze = 1'b0;
    wait_done(6, 2 + (1 + ROWS) + 3, "freeze");

    // Asynchronous reset in the middle of ISSUE abandons the step.
    push(3, "rs");
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    cyc();
    chk("rs_issue_valid", 32'(sr_req_valid), 32'd1);
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk_reset_outputs("midrst");
    cyc();
    reset = 1'b1;
    cyc();
    chk("midrst_no_done", 32'(done_cnt), 32'(exp_steps));
    exp_time = 0;

    // Empty step after reset, with extra ticks while busy.
    tick = 1'b1;
    cyc();
    chk("ovr_c1_busy", 32'(busy), 32'd1);
    cyc();
    chk("ovr_c2_done", 32'(step_done), 32'd1);
    cyc();
    tick = 1'b0;
    exp_steps++;
    chk("post_rst_time", 32'(time_index), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_done_pulses", 32'(done_cnt), 32'(exp_steps));
`ifdef SCHED_OVERRUN_EN
    chk("overrun", 32'(overrun), 32'd1);
    chk("overrun_cnt", 32'(overrun_cnt), 32'd2);
`endif
    cyc();
    cyc();
    chk("busy_ticks_not_queued", 32'(busy), 32'd0);
    chk("busy_ticks_no_extra_done", 32'(done_cnt), 32'(exp_steps));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
